// File: rtl/valid_ready_lfsr_pkg.sv
// rtl/valid_ready_lfsr_pkg.sv - shared LFSR constants and state type for the lfsr source/checker pair
package valid_ready_lfsr_pkg;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [7:0]  THROTTLE_TAPS = 8'hB8;
    localparam logic [7:0]  THROTTLE_SEED = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } lfsr_source_state_t;

endpackage

// File: rtl/valid_ready_lfsr_source_galois_lfsr.sv
// rtl/valid_ready_lfsr_source_galois_lfsr.sv - right-shifting Galois LFSR with seed load and step enable
module galois_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clock) begin
        if (reset || load) begin
            state <= SEED;
        end else if (advance) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/valid_ready_lfsr_source.sv
// rtl/valid_ready_lfsr_source.sv - valid/ready burst source of LFSR words
// Optional offer-rate throttle enabled by VALID_READY_LFSR_SOURCE_THROTTLE_EN.
module valid_ready_lfsr_source
    import valid_ready_lfsr_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          COUNT_WIDTH = 16,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] length,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] sent_count
);

    lfsr_source_state_t     state, state_next;
    logic [COUNT_WIDTH-1:0] length_q;
    logic [COUNT_WIDTH-1:0] sent_inc;
    logic [15:0]            lfsr_state;
    logic                   valid_next;
    logic                   load;
    logic                   handshake;
    logic                   last;
    logic                   offer_ok;

    assign handshake = out_valid & out_ready;
    assign sent_inc  = sent_count + 1'b1;
    assign last      = handshake && (sent_inc == length_q);

    galois_lfsr #(
        .WIDTH (16),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_data_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .advance (handshake),
        .state   (lfsr_state)
    );

`ifdef VALID_READY_LFSR_SOURCE_THROTTLE_EN
    logic [7:0] throttle_state;

    galois_lfsr #(
        .WIDTH (8),
        .TAPS  (THROTTLE_TAPS),
        .SEED  (THROTTLE_SEED)
    ) u_throttle_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .advance (state == RUN),
        .state   (throttle_state)
    );

    assign offer_ok = (throttle_state[1:0] != 2'b00);
`else
    assign offer_ok = 1'b1;
`endif

    always_comb begin
        state_next = state;
        valid_next = out_valid;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (length != '0) begin
                        state_next = RUN;
                        valid_next = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                    valid_next = 1'b0;
                end else if (handshake || !out_valid) begin
                    // A stalled offer is never withdrawn; a new offer is gated by the throttle.
                    valid_next = offer_ok;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            length_q   <= '0;
            sent_count <= '0;
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
            if (load) begin
                length_q   <= length;
                sent_count <= '0;
            end else if (handshake) begin
                sent_count <= sent_inc;
            end
        end
    end

    assign out_data = lfsr_state[WIDTH-1:0];
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

endmodule

// File: doc/valid_ready_lfsr_source.md
# valid_ready_lfsr_source

Single-clock valid/ready stream transmitter that emits a programmable-length burst of pseudo-random words produced by a Galois LFSR. It is the producing end of the valid/ready interface. It drives the write side of the FIFOs and buffers in this library, so benches and on-chip self-test can generate reproducible traffic. The companion checker regenerates the same sequence from the same seed.

## Interface
- `WIDTH`, 8: output data width; legal range 1 to 16.
- `COUNT_WIDTH`, 16: width of the burst length and sent counter.
- `SEED`, 16'hACE1: LFSR value loaded on reset and on every accepted start; must be non-zero.

Ports (name, direction, width, meaning):
- `clock`, in, 1: single clock; everything is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a burst; sampled only in IDLE.
- `length`, in, COUNT_WIDTH: number of words in the burst; sampled together with `start`.
- `out_data`, out, WIDTH: stream data, equal to `lfsr[WIDTH-1:0]`.
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: stream ready from the sink.
- `busy`, out, 1: high in RUN.
- `done`, out, 1: one-cycle pulse when a burst completes.
- `sent_count`, out, COUNT_WIDTH: handshakes accepted in the current or last burst.

## Operation
- States:
  - IDLE → RUN on `start` with `length` ≠ 0.
  - IDLE → DONE on `start` with `length` = 0.
  - RUN → DONE on the handshake that makes `sent_count` equal to the latched length.
  - DONE → IDLE unconditionally.
- Accepted start: latch `length`, load `SEED` into the LFSR, clear `sent_count`.
- `start` in RUN or DONE is ignored.
- Handshake: `out_valid & out_ready` on a rising edge. On each handshake:
  - advance the LFSR: right shift, XOR `LFSR_TAPS` when the shifted-out bit is 1;
  - increment `sent_count`.
- The LFSR advances only on a handshake, so data is stable while stalled.
- Protocol rules:
  - once `out_valid` is high it stays high with `out_data` unchanged until the handshake;
  - `out_valid` never depends combinationally on `out_ready`;
  - `out_ready` high with `out_valid` low has no effect.
- `out_valid` is high in RUN only. It falls on the edge that completes the last handshake.
- `done` is high exactly during the DONE cycle.
- `sent_count` holds its value after DONE until the next accepted start.
- `sent_count` arithmetic is unsigned COUNT_WIDTH. Its maximum is `length`, so it never wraps.
- Reset mid-burst:
  - the burst is abandoned;
  - the next edge yields IDLE, `out_valid` = 0, `done` = 0, `sent_count` = 0, LFSR = `SEED`.

## Timing
- Reset values:
  - `out_valid` 0, `busy` 0, `done` 0, `sent_count` 0;
  - `out_data` = `SEED[WIDTH-1:0]`.
- Start latency: `start` sampled at edge N → `out_valid` high after edge N (first cycle in RUN), unless throttled.
- Throughput: one word per cycle with `out_ready` held high and no throttle.
- A burst of L words with constant ready occupies L RUN cycles, then one DONE cycle.
- Earliest next start is sampled in the cycle after DONE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `VALID_READY_LFSR_SOURCE_THROTTLE_EN`.
- Defined:
  - a second 8-bit LFSR, seeded with `THROTTLE_SEED`, advances every cycle in RUN;
  - while `out_valid` is low in RUN, it rises only when the throttle LFSR low two bits are non-zero (≈75% offer rate);
  - once raised, it holds per the protocol rules.
- Undefined: no throttle logic; `out_valid` is high for every RUN cycle.

## Structure
- Package `valid_ready_lfsr_pkg` holds:
  - `LFSR_TAPS` = 16'hB400;
  - `THROTTLE_TAPS` = 8'hB8;
  - `THROTTLE_SEED` = 8'h01;
  - state enum `lfsr_source_state_t` {IDLE, RUN, DONE}.
- The package is shared with the future checker.
- Sub-module `galois_lfsr`: parameters width, taps and seed; inputs `load`, `advance`; output `state`. It is instantiated once, or twice when throttle is enabled.

## Test plan
- Reset, then idle 5 cycles → `out_valid` 0, `busy` 0, `done` 0, `sent_count` 0, `out_data` 8'hE1.
- `start`, `length`=3, ready always 1 → data E1, 70, 38 on three consecutive cycles; `done` pulses on the 4th cycle; `sent_count`=3.
- `length`=3, `out_ready` low for 4 cycles after valid rises → `out_data` held at E1 and valid held high throughout; sequence E1, 70, 38 intact.
- `start` with `length`=0 → no `out_valid`; `done` pulses on the next cycle; `sent_count` 0.
- `reset` asserted after 2 handshakes of a 10-word burst → next cycle idle values; a new start replays from E1.
- Throttle defined, `length`=100, random ready → 100 handshakes matching the reference LFSR model; valid never drops before a handshake.
